gemm_tiled_array_top: RTL and testbench
=======================================

# gemm_tiled_array_top

Tiled output-stationary GeMM accelerator built around a TileM×TileN array of K-wide MAC PEs. Each array pass consumes one A tile and one B tile per cycle. The block walks arbitrary M/K/N sizes, given in tile units, over SRAMs that store whole tiles per word. It accumulates across the K dimension and writes one C tile per output position through a ready-qualified write port. It is the multi-tile, back-pressure-aware successor of the single-pass array top and sits between the system controller and the three tile SRAMs.

## Interface
- InDataWidth, 8, signed element width of A and B.
- OutDataWidth, 32, signed accumulator and C element width.
- AddrWidth, 16, SRAM word address width.
- SizeAddrWidth, 8, width of the tile-count inputs and internal counters.
- TileM, 4, rows per tile of A and C.
- TileN, 4, columns per tile of B and C.
- TileK, 4, columns of an A tile and rows of a B tile.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- M_tiles_i, K_tiles_i, N_tiles_i  in  SizeAddrWidth each  matrix sizes in tiles; sampled with start_i.
- sram_a_addr_o  out  AddrWidth  A tile address.
- sram_b_addr_o  out  AddrWidth  B tile address.
- sram_a_rdata_i  in  InDataWidth·TileM·TileK  A tile, row-major; element (r,c) is at slice (r·TileK+c).
- sram_b_rdata_i  in  InDataWidth·TileK·TileN  B tile, row-major; element (r,c) is at slice (r·TileN+c).
- sram_c_addr_o  out  AddrWidth  C tile address.
- sram_c_wdata_o  out  OutDataWidth·TileM·TileN  C tile, row-major.
- sram_c_we_o  out  1  C write valid.
- sram_c_ready_i  in  1  C write accepted when high together with sram_c_we_o.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  single-cycle completion pulse.

## Operation
- Loop order: mt (outer), nt, kt (inner). Address formulas:
  - A address = mt·K_tiles + kt.
  - B address = kt·N_tiles + nt.
  - C address = mt·N_tiles + nt.
  - All three are truncated to AddrWidth.
- Sizes are latched on accepted start. start_i is ignored while busy_o is high.
- FSM states: IDLE, COMPUTE, DRAIN, WRITE, DONE.
  - IDLE: on start_i, go to DONE if any size is zero; otherwise go to COMPUTE with all counters at zero.
  - COMPUTE: issue one A/B address pair per cycle and increment kt. After issuing kt = K_tiles−1, go to DRAIN.
  - DRAIN: consume the last tile's data, then go to WRITE.
  - WRITE: hold sram_c_we_o high with stable address and data until sram_c_ready_i is high. On that handshake, kt resets to 0 and nt/mt advance. If the tile just written was the last, go to DONE; otherwise go to COMPUTE.
  - DONE: assert done_o for one cycle, then return to IDLE.
- Datapath: SRAM data for an address issued in cycle t arrives and is consumed in cycle t+1.
  - PE(r,c) computes the sum over i < TileK of A(r,i)·B(i,c). Products are full width, 2·InDataWidth signed.
  - The data beat for kt = 0 loads the accumulator; later beats add to it.
  - Accumulation wraps in two's complement at OutDataWidth.
- sram_c_wdata_o is driven directly by the accumulator registers and is stable throughout WRITE.

## Timing
- Reset values:
  - All addresses and sram_c_wdata_o are 0.
  - sram_c_we_o, busy_o and done_o are 0.
  - State is IDLE.
- Reset mid-operation aborts immediately with no further writes. A new start is accepted normally afterwards.
- Start accepted in cycle S:
  - First address in S+1.
  - First write at S+K_tiles+2.
- Each output tile takes K_tiles+2 cycles plus the number of cycles sram_c_ready_i is held low.
- done_o asserts the cycle after the final write handshake.
- Zero-size start: done_o at S+1, with no address activity and no writes.

## Configuration
- GEMM_SATURATE_EN defined: every accumulator add clamps to the signed OutDataWidth range [−2^(OutDataWidth−1), 2^(OutDataWidth−1)−1].
- GEMM_SATURATE_EN undefined: wrap-around arithmetic, no clamp logic.

## Test plan
- 1×1×1 tiles, A = identity, B elements 1..16, ready tied high → C = B; write at addr 0 in S+3; done_o at S+4.
- 2×2×2 tiles, random signed data → C matches the golden model; writes in address order 0, 1, 2, 3, each K_tiles+2 = 4 cycles apart.
- sram_c_ready_i low for 5 cycles during the first write → we, address and data held stable; no tile lost or duplicated; done_o delayed by 5 cycles.
- K_tiles = 0 with start → done_o at S+1; sram_c_we_o never asserts; start while busy → ignored.
- Reset asserted mid-COMPUTE → all outputs 0 immediately; a subsequent 1×1×1 run is correct.
- OutDataWidth = 16, 1×1×1 tiles, all elements −128 (each sum = 65536) → 0 without GEMM_SATURATE_EN, 32767 with it.

Source files
------------

// File: rtl/gemm_tiled_array_top.sv
// gemm_tiled_array_top: tiled output-stationary GeMM over tile SRAMs; define GEMM_SATURATE_EN for clamping accumulation
module gemm_tiled_array_top #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int TileM         = 4,
    parameter int TileN         = 4,
    parameter int TileK         = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [SizeAddrWidth-1:0]               M_tiles_i,
    input  logic [SizeAddrWidth-1:0]               K_tiles_i,
    input  logic [SizeAddrWidth-1:0]               N_tiles_i,
    output logic [AddrWidth-1:0]                   sram_a_addr_o,
    output logic [AddrWidth-1:0]                   sram_b_addr_o,
    input  logic [InDataWidth*TileM*TileK-1:0]     sram_a_rdata_i,
    input  logic [InDataWidth*TileK*TileN-1:0]     sram_b_rdata_i,
    output logic [AddrWidth-1:0]                   sram_c_addr_o,
    output logic [OutDataWidth*TileM*TileN-1:0]    sram_c_wdata_o,
    output logic                                   sram_c_we_o,
    input  logic                                   sram_c_ready_i,
    output logic                                   busy_o,
    output logic                                   done_o
);
    localparam int NumPe = TileM * TileN;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COMPUTE = 3'd1;
    localparam logic [2:0] DRAIN   = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0] state_q;
    logic [SizeAddrWidth-1:0] m_q, k_q, n_q, mt_q, kt_q, nt_q;
    logic [AddrWidth-1:0] a_base_q, k_ext;
    logic valid_q, first_q;
    logic [OutDataWidth-1:0] acc_q [NumPe];
    logic [OutDataWidth-1:0] acc_d [NumPe];
    logic last_k, last_n, last_tile, c_hs, zero_size;

    assign k_ext       = AddrWidth'(k_q);
    assign last_k      = kt_q == k_q - 1'b1;
    assign last_n      = nt_q == n_q - 1'b1;
    assign last_tile   = last_n && mt_q == m_q - 1'b1;
    assign c_hs        = state_q == WRITE && sram_c_ready_i;
    assign zero_size   = M_tiles_i == '0 || K_tiles_i == '0 || N_tiles_i == '0;
    assign sram_c_we_o = state_q == WRITE;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;

    function automatic logic [OutDataWidth-1:0] mul_f(input logic signed [InDataWidth-1:0] x,
                                                      input logic signed [InDataWidth-1:0] y);
        logic signed [2*InDataWidth-1:0] p;
        p = x * y;
        return OutDataWidth'(p);
    endfunction

    function automatic logic [OutDataWidth-1:0] add_f(input logic [OutDataWidth-1:0] x,
                                                      input logic [OutDataWidth-1:0] y);
`ifdef GEMM_SATURATE_EN
        logic [OutDataWidth:0] s;
        s = {x[OutDataWidth-1], x} + {y[OutDataWidth-1], y};
        return (s[OutDataWidth] != s[OutDataWidth-1]) ?
               {s[OutDataWidth], {(OutDataWidth-1){~s[OutDataWidth]}}} : s[OutDataWidth-1:0];
`else
        return x + y;
`endif
    endfunction

    // Tile walk: counters plus incrementally maintained A/B/C addresses (no multipliers)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            m_q           <= '0;
            k_q           <= '0;
            n_q           <= '0;
            mt_q          <= '0;
            kt_q          <= '0;
            nt_q          <= '0;
            a_base_q      <= '0;
            sram_a_addr_o <= '0;
            sram_b_addr_o <= '0;
            sram_c_addr_o <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i && zero_size) state_q <= DONE;
                else if (start_i) begin
                    state_q       <= COMPUTE;
                    m_q           <= M_tiles_i;
                    k_q           <= K_tiles_i;
                    n_q           <= N_tiles_i;
                    mt_q          <= '0;
                    kt_q          <= '0;
                    nt_q          <= '0;
                    a_base_q      <= '0;
                    sram_a_addr_o <= '0;
                    sram_b_addr_o <= '0;
                    sram_c_addr_o <= '0;
                end
                COMPUTE: begin
                    state_q <= last_k ? DRAIN : COMPUTE;
                    if (!last_k) begin
                        kt_q          <= kt_q + 1'b1;
                        sram_a_addr_o <= sram_a_addr_o + 1'b1;
                        sram_b_addr_o <= sram_b_addr_o + AddrWidth'(n_q);
                    end
                end
                DRAIN: state_q <= WRITE;
                WRITE: if (c_hs) begin
                    state_q       <= last_tile ? DONE : COMPUTE;
                    kt_q          <= '0;
                    sram_c_addr_o <= sram_c_addr_o + 1'b1;
                    nt_q          <= last_n ? '0 : nt_q + 1'b1;
                    mt_q          <= last_n ? mt_q + 1'b1 : mt_q;
                    a_base_q      <= last_n ? a_base_q + k_ext : a_base_q;
                    sram_a_addr_o <= last_n ? a_base_q + k_ext : a_base_q;
                    sram_b_addr_o <= last_n ? '0 : AddrWidth'(nt_q) + 1'b1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Per-PE dot product of the current A row and B column, added onto (or replacing) the accumulator
    always_comb begin
        for (int p = 0; p < NumPe; p++) begin
            acc_d[p] = first_q ? '0 : acc_q[p];
            for (int i = 0; i < TileK; i++)
                acc_d[p] = add_f(acc_d[p],
                    mul_f(sram_a_rdata_i[((p / TileN) * TileK + i) * InDataWidth +: InDataWidth],
                          sram_b_rdata_i[(i * TileN + p % TileN) * InDataWidth +: InDataWidth]));
        end
    end

    // Read data lags its address by one cycle, so the beat tag is delayed to match
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            for (int p = 0; p < NumPe; p++) acc_q[p] <= '0;
        end else begin
            valid_q <= state_q == COMPUTE;
            first_q <= kt_q == '0;
            if (valid_q) acc_q <= acc_d;
        end
    end

    for (genvar g = 0; g < NumPe; g++) begin : g_wdata
        assign sram_c_wdata_o[g*OutDataWidth +: OutDataWidth] = acc_q[g];
    end
endmodule

// File: tb/tb_gemm_tiled_array_top.sv
// tb_gemm_tiled_array_top: directed checks of tile walk, timing, back-pressure, reset and overflow
module tb_gemm_tiled_array_top;
    logic clk_i = 1'b0, rst_ni = 1'b0, start = 1'b0, start2 = 1'b0, c_ready = 1'b1;
    logic [7:0] m_t = '0, k_t = '0, n_t = '0;
    logic [15:0] a_addr, b_addr, c_addr, a_addr2, b_addr2, c_addr2;
    logic [127:0] a_rdata = '0, b_rdata = '0;
    logic [127:0] rdata2 = {16{8'h80}};
    logic [511:0] c_wdata;
    logic [255:0] c_wdata2;
    logic c_we, busy, done, c_we2, busy2, done2;
    logic [127:0] mem_a [16];
    logic [127:0] mem_b [16];
    int checks = 0, errors = 0;
    int cyc = 0, s_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic [15:0] wq_addr [$];
    logic [511:0] wq_data [$];
    int wq_cyc [$];

    always #5 clk_i = ~clk_i;

    gemm_tiled_array_top dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start),
        .M_tiles_i(m_t), .K_tiles_i(k_t), .N_tiles_i(n_t),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr),
        .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
        .sram_c_addr_o(c_addr), .sram_c_wdata_o(c_wdata), .sram_c_we_o(c_we),
        .sram_c_ready_i(c_ready), .busy_o(busy), .done_o(done)
    );

    gemm_tiled_array_top #(.OutDataWidth(16)) dut16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start2),
        .M_tiles_i(8'd1), .K_tiles_i(8'd1), .N_tiles_i(8'd1),
        .sram_a_addr_o(a_addr2), .sram_b_addr_o(b_addr2),
        .sram_a_rdata_i(rdata2), .sram_b_rdata_i(rdata2),
        .sram_c_addr_o(c_addr2), .sram_c_wdata_o(c_wdata2), .sram_c_we_o(c_we2),
        .sram_c_ready_i(1'b1), .busy_o(busy2), .done_o(done2)
    );

    always @(posedge clk_i) begin
        a_rdata <= mem_a[a_addr[3:0]];
        b_rdata <= mem_b[b_addr[3:0]];
    end

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (c_we && c_ready) begin
            wq_addr.push_back(c_addr);
            wq_data.push_back(c_wdata);
            wq_cyc.push_back(cyc);
        end
        if (start && !busy && rst_ni) s_cyc <= cyc;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    function automatic logic [511:0] ident_exp();
        logic [511:0] x;
        for (int e = 0; e < 16; e++) x[e*32 +: 32] = 32'(e + 1);
        return x;
    endfunction

    function automatic logic [511:0] gold(int mt, int nt, int kk, int nn);
        logic [511:0] x;
        int s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int kt = 0; kt < kk; kt++)
                    for (int i = 0; i < 4; i++)
                        s += $signed(mem_a[mt*kk+kt][(r*4+i)*8 +: 8]) * $signed(mem_b[kt*nn+nt][(i*4+c)*8 +: 8]);
                x[(r*4+c)*32 +: 32] = s;
            end
        return x;
    endfunction

    task automatic load_identity();
        mem_a[0] = '0;
        for (int r = 0; r < 4; r++) mem_a[0][(r*4+r)*8 +: 8] = 8'd1;
        for (int e = 0; e < 16; e++) mem_b[0][e*8 +: 8] = 8'(e + 1);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic do_start(input logic [7:0] mm, input logic [7:0] kk, input logic [7:0] nn);
        @(negedge clk_i);
        m_t = mm; k_t = kk; n_t = nn; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string nm);
        int i = 0;
        while (done_cnt == prev && i < 300) begin
            @(posedge clk_i);
            i++;
        end
        #1;
        checks++;
        if (done_cnt == prev) begin
            errors++;
            $display("FAIL %s_timeout: done_o not seen within 300 cycles", nm);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy, c_we, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/we/done=%b required 000", {busy, c_we, done});
        end
        checks++;
        if ({a_addr, b_addr, c_addr} !== 48'd0 || c_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h c=%h wdata=%h required all 0", a_addr, b_addr, c_addr, c_wdata);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_identity();
        int prev;
        load_identity();
        clear_log();
        prev = done_cnt;
        do_start(8'd1, 8'd1, 8'd1);
        wait_done(prev, "identity");
        checks++;
        if (wq_addr.size() != 1) begin
            errors++;
            $display("FAIL identity_count: writes=%0d required 1", wq_addr.size());
        end else begin
            checks += 3;
            if (wq_addr[0] !== 16'd0) begin
                errors++;
                $display("FAIL identity_addr: got %0d required 0", wq_addr[0]);
            end
            if (wq_data[0] !== ident_exp()) begin
                errors++;
                $display("FAIL identity_data: got %h required %h", wq_data[0], ident_exp());
            end
            if (wq_cyc[0] - s_cyc != 3) begin
                errors++;
                $display("FAIL identity_wlat: got S+%0d required S+3", wq_cyc[0] - s_cyc);
            end
        end
        checks++;
        if (done_cyc - s_cyc != 4) begin
            errors++;
            $display("FAIL identity_done: got S+%0d required S+4", done_cyc - s_cyc);
        end
    endtask

    task automatic test_multi_tile();
        int prev;
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < 16; e++) begin
                mem_a[t][e*8 +: 8] = 8'((t*16+e)*53 + 17);
                mem_b[t][e*8 +: 8] = 8'((t*16+e)*29 + 101);
            end
        clear_log();
        prev = done_cnt;
        do_start(8'd2, 8'd2, 8'd2);
        wait_done(prev, "multi");
        checks++;
        if (wq_addr.size() != 4) begin
            errors++;
            $display("FAIL multi_count: writes=%0d required 4", wq_addr.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks += 3;
                if (wq_addr[j] !== 16'(j)) begin
                    errors++;
                    $display("FAIL multi_addr%0d: got %0d required %0d", j, wq_addr[j], j);
                end
                if (wq_data[j] !== gold(j / 2, j % 2, 2, 2)) begin
                    errors++;
                    $display("FAIL multi_data%0d: got %h required %h", j, wq_data[j], gold(j / 2, j % 2, 2, 2));
                end
                if ((j == 0 ? wq_cyc[0] - s_cyc : wq_cyc[j] - wq_cyc[j-1]) != 4) begin
                    errors++;
                    $display("FAIL multi_gap%0d: got %0d cycles required 4", j,
                             j == 0 ? wq_cyc[0] - s_cyc : wq_cyc[j] - wq_cyc[j-1]);
                end
            end
        end
        checks++;
        if (done_cyc - s_cyc != 17) begin
            errors++;
            $display("FAIL multi_done: got S+%0d required S+17", done_cyc - s_cyc);
        end
    endtask

    task automatic test_backpressure();
        int prev, i;
        logic [511:0] exp1;
        load_identity();
        for (int e = 0; e < 16; e++) begin
            mem_b[1][e*8 +: 8] = 8'(-(e + 1));
            exp1[e*32 +: 32] = 32'(-(e + 1));
        end
        clear_log();
        prev = done_cnt;
        c_ready = 1'b0;
        do_start(8'd1, 8'd1, 8'd2);
        i = 0;
        while (!c_we && i < 20) begin
            @(negedge clk_i);
            i++;
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if ({c_we, c_addr, c_wdata} !== {1'b1, 16'd0, ident_exp()}) begin
                errors++;
                $display("FAIL bp_hold%0d: we=%b addr=%0d wdata=%h required we=1 addr=0 wdata=%h",
                         j, c_we, c_addr, c_wdata, ident_exp());
            end
            @(negedge clk_i);
        end
        c_ready = 1'b1;
        wait_done(prev, "bp");
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL bp_count: writes=%0d required 2", wq_addr.size());
        end else begin
            checks += 2;
            if ({wq_addr[0], wq_addr[1]} !== {16'd0, 16'd1} || wq_data[0] !== ident_exp() || wq_data[1] !== exp1) begin
                errors++;
                $display("FAIL bp_tiles: addrs %0d,%0d data1=%h required 0,1 data1=%h",
                         wq_addr[0], wq_addr[1], wq_data[1], exp1);
            end
            if (wq_cyc[0] - s_cyc != 8 || wq_cyc[1] - s_cyc != 11) begin
                errors++;
                $display("FAIL bp_wcyc: got S+%0d,S+%0d required S+8,S+11", wq_cyc[0] - s_cyc, wq_cyc[1] - s_cyc);
            end
        end
        checks++;
        if (done_cyc - s_cyc != 12) begin
            errors++;
            $display("FAIL bp_done: got S+%0d required S+12", done_cyc - s_cyc);
        end
    endtask

    task automatic test_zero_and_busy();
        int prev;
        clear_log();
        prev = done_cnt;
        do_start(8'd1, 8'd0, 8'd1);
        wait_done(prev, "zero");
        repeat (3) @(negedge clk_i);
        checks += 2;
        if (done_cyc - s_cyc != 1) begin
            errors++;
            $display("FAIL zero_done: got S+%0d required S+1", done_cyc - s_cyc);
        end
        if (wq_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_writes: writes=%0d required 0", wq_addr.size());
        end
        load_identity();
        clear_log();
        prev = done_cnt;
        do_start(8'd1, 8'd1, 8'd1);
        k_t = 8'd0;
        start = 1'b1;
        repeat (2) @(negedge clk_i);
        start = 1'b0;
        wait_done(prev, "busy");
        repeat (4) @(negedge clk_i);
        checks += 3;
        if (done_cnt != prev + 1) begin
            errors++;
            $display("FAIL busy_donecnt: done pulses=%0d required 1", done_cnt - prev);
        end
        if (done_cyc - s_cyc != 4) begin
            errors++;
            $display("FAIL busy_done: got S+%0d required S+4", done_cyc - s_cyc);
        end
        if (wq_data.size() != 1 || wq_data[0] !== ident_exp()) begin
            errors++;
            $display("FAIL busy_write: writes=%0d required 1 with identity result", wq_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int prev;
        clear_log();
        do_start(8'd2, 8'd2, 8'd2);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks += 2;
        if ({busy, c_we, done} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_ctrl: busy/we/done=%b required 000", {busy, c_we, done});
        end
        if ({a_addr, b_addr, c_addr} !== 48'd0 || c_wdata !== '0) begin
            errors++;
            $display("FAIL rstmid_data: a=%h b=%h c=%h required all 0", a_addr, b_addr, c_addr);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (wq_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: writes=%0d busy=%b required 0 writes, busy 0", wq_addr.size(), busy);
        end
        load_identity();
        clear_log();
        prev = done_cnt;
        do_start(8'd1, 8'd1, 8'd1);
        wait_done(prev, "rstmid");
        checks++;
        if (wq_data.size() != 1 || wq_data[0] !== ident_exp() || wq_cyc[0] - s_cyc != 3) begin
            errors++;
            $display("FAIL rstmid_rerun: writes=%0d required one identity write at S+3", wq_data.size());
        end
    endtask

    task automatic test_overflow();
        int i = 0;
        logic [255:0] exp2;
`ifdef GEMM_SATURATE_EN
        exp2 = {16{16'h7fff}};
`else
        exp2 = '0;
`endif
        @(negedge clk_i);
        start2 = 1'b1;
        @(negedge clk_i);
        start2 = 1'b0;
        while (!c_we2 && i < 20) begin
            @(negedge clk_i);
            i++;
        end
        checks++;
        if (c_we2 !== 1'b1 || c_wdata2 !== exp2) begin
            errors++;
            $display("FAIL overflow16: we=%b wdata=%h required we=1 wdata=%h", c_we2, c_wdata2, exp2);
        end
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_multi_tile();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
